// File: rtl/sifh_pkg.sv
// Shared parameters and types for the SiFH TDC front end.
// Values mirror parametersSiFH.vh so downstream blocks agree on widths.
package sifh_pkg;

    localparam int unsigned NP        = 10;
    localparam int unsigned PIXEL_NUM = 2;
    localparam int unsigned ACQ_NUM   = 3;
    localparam int unsigned DATA_NUM  = 2;

    typedef logic [NP-1:0] ts_t;

    localparam ts_t NO_HIT = ts_t'((2 ** NP) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int unsigned WORDS = PIXEL_NUM * ACQ_NUM * DATA_NUM;

    // Counter widths hold the full count; index widths address one array entry.
    localparam int unsigned ACQ_CW  = $clog2(ACQ_NUM + 1);
    localparam int unsigned SLOT_CW = $clog2(DATA_NUM + 1);
    localparam int unsigned RD_CW   = $clog2(WORDS + 1);
    localparam int unsigned ACQ_IW  = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;
    localparam int unsigned SLOT_IW = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;

endpackage

// File: rtl/pixel_hit_slot.sv
// Per-pixel hit slot allocator: counts accepted hits in the open acquisition
// and flags hits that arrive once every slot is taken.
module pixel_hit_slot
    import sifh_pkg::*;
(
    input  logic               clk_i,
    input  logic               res_i,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic               hit_valid_i,
    output logic               wr_en_o,
    output logic [SLOT_IW-1:0] slot_idx_o,
    output logic               drop_o
);

    logic [SLOT_CW-1:0] slot_cnt_q, slot_cnt_d;
    logic               full;

    assign full       = (slot_cnt_q == SLOT_CW'(DATA_NUM));
    assign wr_en_o    = en_i && hit_valid_i && !full;
    assign drop_o     = en_i && hit_valid_i && full;
    assign slot_idx_o = slot_cnt_q[SLOT_IW-1:0];

    always_comb begin
        slot_cnt_d = slot_cnt_q;
        if (clr_i) begin
            slot_cnt_d = '0;
        end else if (wr_en_o) begin
            slot_cnt_d = slot_cnt_q + SLOT_CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (res_i) begin
            slot_cnt_q <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
        end
    end

endmodule

// File: rtl/tdc_frame_sequencer.sv
// Captures per-pixel TDC hits over ACQ_NUM acquisitions, then streams the frame
// pixel-major / acquisition / slot as one word per clock to hisBuilderFSM.
module tdc_frame_sequencer
    import sifh_pkg::*;
(
    input  logic                    clk,
    input  logic                    res,
    input  logic                    acq_start,
    input  logic                    acq_end,
    input  logic [PIXEL_NUM-1:0]    hit_valid,
    input  logic [PIXEL_NUM*NP-1:0] hit_data,
    output logic                    busy,
    output logic                    wrEn,
    output ts_t                     data,
    output logic                    frame_done,
    output logic                    overflow
);

    state_t            state_q, state_d;
    logic [ACQ_CW-1:0] acq_cnt_q, acq_cnt_d;
    logic [RD_CW-1:0]  rd_idx_q, rd_idx_d;

    ts_t  [PIXEL_NUM-1:0][ACQ_NUM-1:0][DATA_NUM-1:0] buf_q, buf_d;
    logic [PIXEL_NUM-1:0][ACQ_NUM-1:0][DATA_NUM-1:0] vld_q, vld_d;

    logic wren_q, wren_d;
    ts_t  data_q, data_d;
    logic frame_done_q, frame_done_d;
    logic overflow_q, overflow_d;

    logic [PIXEL_NUM-1:0] slot_wr, slot_drop;
    logic [SLOT_IW-1:0]   slot_idx [PIXEL_NUM];
    logic                 slot_clr, slot_en;
    logic [ACQ_IW-1:0]    acq_row;
    ts_t                  rd_word;

    assign slot_clr = (state_q == IDLE) && acq_start;
    assign slot_en  = (state_q == ACQ);
    assign acq_row  = acq_cnt_q[ACQ_IW-1:0];

    for (genvar p = 0; p < PIXEL_NUM; p++) begin : g_pix
        pixel_hit_slot u_slot (
            .clk_i       (clk),
            .res_i       (res),
            .clr_i       (slot_clr),
            .en_i        (slot_en),
            .hit_valid_i (hit_valid[p]),
            .wr_en_o     (slot_wr[p]),
            .slot_idx_o  (slot_idx[p]),
            .drop_o      (slot_drop[p])
        );
    end

    // Flat read index with slot fastest; unwritten entries read as NO_HIT.
    always_comb begin
        rd_word = NO_HIT;
        for (int p = 0; p < PIXEL_NUM; p++) begin
            for (int a = 0; a < ACQ_NUM; a++) begin
                for (int s = 0; s < DATA_NUM; s++) begin
                    if (rd_idx_q == RD_CW'((p * ACQ_NUM + a) * DATA_NUM + s) && vld_q[p][a][s]) begin
                        rd_word = buf_q[p][a][s];
                    end
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        acq_cnt_d    = acq_cnt_q;
        rd_idx_d     = rd_idx_q;
        buf_d        = buf_q;
        vld_d        = vld_q;
        wren_d       = 1'b0;
        data_d       = data_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;

        case (state_q)
            IDLE: begin
                if (acq_start) begin
                    for (int p = 0; p < PIXEL_NUM; p++) begin
                        vld_d[p][acq_row] = '0;
                    end
                    state_d = ACQ;
                end
            end
            ACQ: begin
                for (int p = 0; p < PIXEL_NUM; p++) begin
                    if (slot_wr[p]) begin
                        buf_d[p][acq_row][slot_idx[p]] = hit_data[p*NP +: NP];
                        vld_d[p][acq_row][slot_idx[p]] = 1'b1;
                    end
                end
                if (|slot_drop) begin
                    overflow_d = 1'b1;
                end
                if (acq_end) begin
                    if (acq_cnt_q < ACQ_CW'(ACQ_NUM - 1)) begin
                        acq_cnt_d = acq_cnt_q + ACQ_CW'(1);
                        state_d   = IDLE;
                    end else begin
                        state_d    = DRAIN;
                        rd_idx_d   = '0;
                        overflow_d = 1'b0;
                    end
                end
            end
            DRAIN: begin
                wren_d = 1'b1;
                data_d = rd_word;
                if (rd_idx_q == RD_CW'(WORDS - 1)) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                    acq_cnt_d    = '0;
                end else begin
                    rd_idx_d = rd_idx_q + RD_CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q      <= IDLE;
            acq_cnt_q    <= '0;
            rd_idx_q     <= '0;
            vld_q        <= '0;
            wren_q       <= 1'b0;
            data_q       <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            acq_cnt_q    <= acq_cnt_d;
            rd_idx_q     <= rd_idx_d;
            vld_q        <= vld_d;
            wren_q       <= wren_d;
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    // Timestamp storage needs no reset: the valid bits qualify every entry.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign busy       = (state_q == DRAIN);
    assign wrEn       = wren_q;
    assign data       = data_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_tdc_frame_sequencer.sv
// Bench for tdc_frame_sequencer: directed frames plus random frames checked
// every cycle against a queue-based model of captured hits and the drain stream.
module tb_tdc_frame_sequencer;
    import sifh_pkg::*;

    localparam int PH_CLOSED = 0;
    localparam int PH_OPEN   = 1;
    localparam int PH_DRAIN  = 2;

    logic                    clk = 1'b0;
    logic                    res;
    logic                    acq_start;
    logic                    acq_end;
    logic [PIXEL_NUM-1:0]    hit_valid;
    logic [PIXEL_NUM*NP-1:0] hit_data;
    logic                    busy;
    logic                    wrEn;
    logic [NP-1:0]           data;
    logic                    frame_done;
    logic                    overflow;

    always #5 clk = ~clk;

    tdc_frame_sequencer dut (
        .clk        (clk),
        .res        (res),
        .acq_start  (acq_start),
        .acq_end    (acq_end),
        .hit_valid  (hit_valid),
        .hit_data   (hit_data),
        .busy       (busy),
        .wrEn       (wrEn),
        .data       (data),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: accepted hits per pixel/acquisition and the words still to be streamed.
    int hits_q [PIXEL_NUM][ACQ_NUM][$];
    int exp_q [$];
    int m_phase      = PH_CLOSED;
    int m_acq        = 0;
    int m_drain_left = 0;
    bit m_ovf        = 1'b0;
    bit m_emit       = 1'b0;
    int m_last       = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PIXEL_NUM*NP-1:0] pk(input int p0, input int p1);
        logic [PIXEL_NUM*NP-1:0] r;
        r = '0;
        r[0 +: NP]  = NP'(p0);
        r[NP +: NP] = NP'(p1);
        return r;
    endfunction

    function automatic logic [PIXEL_NUM*NP-1:0] rand_hd();
        logic [PIXEL_NUM*NP-1:0] r;
        for (int p = 0; p < PIXEL_NUM; p++) r[p*NP +: NP] = NP'($urandom_range(0, 1022));
        return r;
    endfunction

    function automatic logic [PIXEL_NUM-1:0] rand_hv();
        logic [PIXEL_NUM-1:0] r;
        for (int p = 0; p < PIXEL_NUM; p++) r[p] = ($urandom_range(0, 99) < 40);
        return r;
    endfunction

    task automatic model_edge(input bit s, input bit e, input logic [PIXEL_NUM-1:0] hv,
                              input logic [PIXEL_NUM*NP-1:0] hd);
        m_emit = (m_phase == PH_DRAIN);
        if (m_phase == PH_CLOSED) begin
            if (s) begin
                for (int p = 0; p < PIXEL_NUM; p++) hits_q[p][m_acq].delete();
                m_phase = PH_OPEN;
            end
        end else if (m_phase == PH_OPEN) begin
            for (int p = 0; p < PIXEL_NUM; p++) begin
                if (hv[p]) begin
                    if (hits_q[p][m_acq].size() < DATA_NUM) hits_q[p][m_acq].push_back(int'(hd[p*NP +: NP]));
                    else m_ovf = 1'b1;
                end
            end
            if (e) begin
                if (m_acq < ACQ_NUM - 1) begin
                    m_acq++;
                    m_phase = PH_CLOSED;
                end else begin
                    for (int p = 0; p < PIXEL_NUM; p++)
                        for (int a = 0; a < ACQ_NUM; a++)
                            for (int sl = 0; sl < DATA_NUM; sl++)
                                exp_q.push_back(sl < hits_q[p][a].size() ? hits_q[p][a][sl] : 1023);
                    m_phase      = PH_DRAIN;
                    m_drain_left = WORDS;
                    m_ovf        = 1'b0;
                end
            end
        end else begin
            m_drain_left--;
            if (m_drain_left == 0) begin
                m_phase = PH_CLOSED;
                m_acq   = 0;
            end
        end
    endtask

    task automatic do_cycle(input bit s, input bit e, input logic [PIXEL_NUM-1:0] hv,
                            input logic [PIXEL_NUM*NP-1:0] hd);
        int w;
        res       = 1'b0;
        acq_start = s;
        acq_end   = e;
        hit_valid = hv;
        hit_data  = hd;
        @(posedge clk);
        model_edge(s, e, hv, hd);
        #1;
        check_val("wrEn", 32'(wrEn), 32'(m_emit));
        if (m_emit) begin
            w = exp_q.pop_front();
            check_val("data", 32'(data), 32'(w));
            check_val("frame_done", 32'(frame_done), 32'(exp_q.size() == 0));
            m_last = w;
        end else begin
            check_val("frame_done_idle", 32'(frame_done), 32'd0);
            check_val("data_hold", 32'(data), 32'(m_last));
        end
        check_val("busy", 32'(busy), 32'(m_phase == PH_DRAIN));
        check_val("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic do_reset(input int n);
        res       = 1'b1;
        acq_start = 1'b0;
        acq_end   = 1'b0;
        hit_valid = '1;
        hit_data  = rand_hd();
        repeat (n) @(posedge clk);
        m_phase = PH_CLOSED;
        m_acq   = 0;
        m_ovf   = 1'b0;
        m_emit  = 1'b0;
        m_last  = 0;
        exp_q.delete();
        for (int p = 0; p < PIXEL_NUM; p++)
            for (int a = 0; a < ACQ_NUM; a++) hits_q[p][a].delete();
        #1;
        check_val("rst_wrEn", 32'(wrEn), 32'd0);
        check_val("rst_data", 32'(data), 32'd0);
        check_val("rst_frame_done", 32'(frame_done), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_overflow", 32'(overflow), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) do_cycle(1'b0, ($urandom_range(0, 4) == 0), rand_hv(), rand_hd());
    endtask

    task automatic rand_acq();
        idle($urandom_range(0, 2));
        do_cycle(1'b1, 1'b0, rand_hv(), rand_hd());
        repeat ($urandom_range(0, 6)) do_cycle(1'b0, 1'b0, rand_hv(), rand_hd());
        do_cycle(1'b0, 1'b1, rand_hv(), rand_hd());
    endtask

    task automatic rand_frame();
        repeat (ACQ_NUM) rand_acq();
        idle(WORDS + 2);
    endtask

    initial begin
        res       = 1'b1;
        acq_start = 1'b0;
        acq_end   = 1'b0;
        hit_valid = '0;
        hit_data  = '0;
        do_reset(2);

        // Two hits per pixel per acquisition; start-cycle hits dropped, end-cycle hits kept.
        do_cycle(1'b1, 1'b0, 2'b11, pk(5, 6));
        do_cycle(1'b0, 1'b0, 2'b11, pk(108, 300));
        do_cycle(1'b0, 1'b1, 2'b11, pk(511, 301));
        do_cycle(1'b1, 1'b0, 2'b11, pk(7, 8));
        do_cycle(1'b0, 1'b0, 2'b11, pk(110, 400));
        do_cycle(1'b0, 1'b1, 2'b11, pk(111, 401));
        do_cycle(1'b1, 1'b0, 2'b00, pk(0, 0));
        do_cycle(1'b0, 1'b0, 2'b11, pk(120, 410));
        do_cycle(1'b0, 1'b1, 2'b11, pk(121, 411));
        // acq_start pulsed mid-drain must be ignored.
        repeat (3) do_cycle(1'b0, 1'b0, 2'b00, pk(0, 0));
        do_cycle(1'b1, 1'b0, 2'b11, pk(1, 1));
        idle(WORDS);

        // Overflow on pixel0 acq0; pixel1 sparse in acq1/acq2.
        do_cycle(1'b1, 1'b0, 2'b00, pk(0, 0));
        do_cycle(1'b0, 1'b0, 2'b01, pk(200, 0));
        do_cycle(1'b0, 1'b0, 2'b01, pk(90, 0));
        do_cycle(1'b0, 1'b0, 2'b01, pk(300, 0));
        do_cycle(1'b0, 1'b1, 2'b00, pk(0, 0));
        do_cycle(1'b1, 1'b0, 2'b00, pk(0, 0));
        do_cycle(1'b0, 1'b0, 2'b10, pk(0, 1022));
        do_cycle(1'b0, 1'b1, 2'b00, pk(0, 0));
        do_cycle(1'b1, 1'b0, 2'b00, pk(0, 0));
        do_cycle(1'b0, 1'b1, 2'b00, pk(0, 0));
        idle(WORDS + 2);

        // Reset after the fifth drained word, then a fresh frame.
        repeat (ACQ_NUM) rand_acq();
        repeat (5) do_cycle(1'b0, 1'b0, rand_hv(), rand_hd());
        do_reset(1);
        rand_frame();

        repeat (25) rand_frame();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
